// File: rtl/fft_output_sequencer_if.sv
// Result-RAM read port and output stream of the FFT output sequencer.
//   rd_en/rd_addr  : read strobe and address toward the result RAM
//   rd_data        : RAM word {re,im}, valid the cycle after rd_en
//   dout*          : valid/ready output stream with index and last flag
// master = sequencer side, slave = RAM + downstream consumer side.
interface fft_output_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [2*DATA_W-1:0]   rd_data;
  logic [2*DATA_W-1:0]   dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [ADDR_W-1:0]     dout_idx;
  logic                  dout_last;

  modport master (
    output rd_en, rd_addr, dout, dout_valid, dout_idx, dout_last,
    input  rd_data, dout_ready
  );

  modport slave (
    input  rd_en, rd_addr, dout, dout_valid, dout_idx, dout_last,
    output rd_data, dout_ready
  );
endinterface

// File: rtl/fft_output_sequencer.sv
// Unload side of the FFT: after start, reads all N_POINTS result words from
// a 1-cycle-latency RAM (bit-reversed addresses when BITREV=1) and streams
// them out in natural order through a 2-entry FIFO.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin unloading a frame (sampled only in IDLE)
//   busy     : frame in progress
//   trig     : 1-cycle pulse after beat TRIG_IDX is accepted
//   done     : 1-cycle pulse after beat N_POINTS-1 is accepted
//   bus      : RAM read port + output stream (master modport)
module fft_output_sequencer #(
  parameter int N_POINTS = 64,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int BITREV   = 1,
  parameter int TRIG_IDX = 53
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic trig,
  output logic done,
  fft_output_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] TRIG_K = ADDR_W'(TRIG_IDX);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                inflight_q;
  logic [1:0]          cnt_q;
  logic                wp_q, rp_q;
  logic [2*DATA_W-1:0] mem_q [2];
  logic [ADDR_W-1:0]   out_cnt_q;
  logic                trig_q, done_q;

  logic                pop, push, rd_en_c, last_acc;
  logic [2:0]          credit;
  logic [ADDR_W-1:0]   rd_addr_c;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  assign pop       = (cnt_q != 2'd0) && bus.dout_ready;
  assign push      = inflight_q;
  assign last_acc  = pop && (out_cnt_q == LAST_K);
  assign rd_addr_c = (BITREV != 0) ? bitrev(k_q) : k_q;

  // Occupancy counts the head as already gone when it is popped this cycle;
  // otherwise steady state (1 held + 1 in flight) would stall every other
  // cycle. Returning data still always finds a free slot.
  assign credit  = 3'(cnt_q) - 3'(pop) + 3'(inflight_q);
  assign rd_en_c = (state_q == STREAM) && (credit < 3'd2);

  assign bus.rd_en      = rd_en_c;
  assign bus.rd_addr    = rd_en_c ? rd_addr_c : addr_q;
  assign bus.dout       = mem_q[rp_q];
  assign bus.dout_valid = (cnt_q != 2'd0);
  assign bus.dout_idx   = out_cnt_q;
  assign bus.dout_last  = (cnt_q != 2'd0) && (out_cnt_q == LAST_K);
  assign busy           = (state_q != IDLE);
  assign trig           = trig_q;
  assign done           = done_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        k_d     = '0;
      end
      STREAM: if (rd_en_c) begin
        if (k_q == LAST_K) state_d = DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      DRAIN: if (last_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      out_cnt_q  <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      inflight_q <= rd_en_c;
      if (rd_en_c) addr_q <= rd_addr_c;
      if (push) begin
        mem_q[wp_q] <= bus.rd_data;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q      <= ~rp_q;
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (state_q == IDLE && start) out_cnt_q <= '0;
      cnt_q  <= cnt_q + 2'(push) - 2'(pop);
      trig_q <= pop && (out_cnt_q == TRIG_K);
      done_q <= last_acc;
    end
  end

endmodule

// File: tb/tb_fft_output_sequencer.sv
module tb_fft_output_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start1, start0;
  logic busy1, trig1, done1, busy0, trig0, done0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft_output_sequencer_if #(.ADDR_W(6), .DATA_W(16)) b1 ();
  fft_output_sequencer_if #(.ADDR_W(6), .DATA_W(16)) b0 ();

  fft_output_sequencer #(.BITREV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1),
    .trig(trig1), .done(done1), .bus(b1));
  fft_output_sequencer #(.BITREV(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0),
    .trig(trig0), .done(done0), .bus(b0));

  function automatic logic [31:0] ram(input logic [5:0] a);
    return {10'h2A5, a, 10'h13C, ~a};
  endfunction

  function automatic logic [5:0] brev(input logic [5:0] a);
    logic [5:0] r;
    r = {<<{a}};
    return r;
  endfunction

  // result RAMs: 1-cycle synchronous read
  always @(posedge clk) begin
    if (rst) b1.rd_data <= '0;
    else if (b1.rd_en) b1.rd_data <= ram(b1.rd_addr);
  end
  always @(posedge clk) begin
    if (rst) b0.rd_data <= '0;
    else if (b0.rd_en) b0.rd_data <= ram(b0.rd_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 0; start0 = 0; b1.dout_ready = 0; b0.dout_ready = 0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy1, trig1, done1, b1.rd_en, b1.rd_addr, b1.dout, b1.dout_valid,
         b1.dout_idx, b1.dout_last} !== '0) begin
      n_err++; $display("FAIL reset_dut1 got busy=%b rd_en=%b addr=%0d dout=%h v=%b idx=%0d last=%b trig=%b done=%b want all 0",
        busy1, b1.rd_en, b1.rd_addr, b1.dout, b1.dout_valid, b1.dout_idx, b1.dout_last, trig1, done1);
    end
    n_vec++;
    if ({busy0, trig0, done0, b0.rd_en, b0.rd_addr, b0.dout, b0.dout_valid,
         b0.dout_idx, b0.dout_last} !== '0) begin
      n_err++; $display("FAIL reset_dut0 got nonzero outputs want all 0");
    end
    tick();
  endtask

  task automatic test_basic();
    b1.dout_ready = 1; start1 = 1;
    tick(); start1 = 0;
    for (int c = 1; c <= 68; c++) begin
      #1;
      n_vec++;
      if (busy1 !== (c <= 66)) begin n_err++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy1, c <= 66); end
      n_vec++;
      if (b1.rd_en !== (c <= 64)) begin n_err++; $display("FAIL basic_rd_en c=%0d got %b want %b", c, b1.rd_en, c <= 64); end
      if (c <= 64) begin
        n_vec++;
        if (b1.rd_addr !== brev(6'(c-1))) begin n_err++; $display("FAIL basic_rd_addr c=%0d got %0d want %0d", c, b1.rd_addr, brev(6'(c-1))); end
      end
      n_vec++;
      if (b1.dout_valid !== (c >= 3 && c <= 66)) begin n_err++; $display("FAIL basic_valid c=%0d got %b", c, b1.dout_valid); end
      if (c >= 3 && c <= 66) begin
        n_vec++;
        if (b1.dout_idx !== 6'(c-3) || b1.dout !== ram(brev(6'(c-3))) || b1.dout_last !== (c == 66)) begin
          n_err++; $display("FAIL basic_beat c=%0d got idx=%0d dout=%h last=%b want idx=%0d dout=%h last=%b",
            c, b1.dout_idx, b1.dout, b1.dout_last, c-3, ram(brev(6'(c-3))), c == 66);
        end
      end
      n_vec++;
      if (trig1 !== (c == 57)) begin n_err++; $display("FAIL basic_trig c=%0d got %b want %b", c, trig1, c == 57); end
      n_vec++;
      if (done1 !== (c == 67)) begin n_err++; $display("FAIL basic_done c=%0d got %b want %b", c, done1, c == 67); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int issued = 0, nexp = 0;
    logic seen = 0, prev_stall = 0, pop;
    logic [31:0] prev_dout = '0;
    logic [5:0] prev_idx = '0;
    start1 = 1; b1.dout_ready = 1;
    tick(); start1 = 0;
    for (int c = 1; c <= 600 && !seen; c++) begin
      b1.dout_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      pop = b1.dout_valid && b1.dout_ready;
      if (b1.rd_en) begin
        n_vec++;
        if (issued + 1 - nexp - int'(pop) > 2) begin
          n_err++; $display("FAIL bp_credit c=%0d outstanding=%0d want <=2", c, issued + 1 - nexp - int'(pop));
        end
        issued++;
      end
      if (prev_stall) begin
        n_vec++;
        if (b1.dout_valid !== 1'b1 || b1.dout !== prev_dout || b1.dout_idx !== prev_idx) begin
          n_err++; $display("FAIL bp_stable c=%0d got v=%b dout=%h idx=%0d want dout=%h idx=%0d",
            c, b1.dout_valid, b1.dout, b1.dout_idx, prev_dout, prev_idx);
        end
      end
      if (b1.dout_valid) begin
        n_vec++;
        if (b1.dout_idx !== 6'(nexp) || b1.dout !== ram(brev(6'(nexp)))) begin
          n_err++; $display("FAIL bp_beat c=%0d got idx=%0d dout=%h want idx=%0d dout=%h",
            c, b1.dout_idx, b1.dout, nexp, ram(brev(6'(nexp))));
        end
      end
      if (pop) nexp++;
      if (done1) seen = 1;
      prev_stall = b1.dout_valid && !b1.dout_ready;
      prev_dout  = b1.dout;
      prev_idx   = b1.dout_idx;
      tick();
    end
    n_vec++;
    if (!seen || nexp != 64 || issued != 64) begin
      n_err++; $display("FAIL bp_total got done=%b beats=%0d reads=%0d want 1 64 64", seen, nexp, issued);
    end
    b1.dout_ready = 1;
  endtask

  task automatic test_natural();
    b0.dout_ready = 1; start0 = 1;
    tick(); start0 = 0;
    for (int c = 1; c <= 68; c++) begin
      #1;
      if (c <= 64) begin
        n_vec++;
        if (b0.rd_en !== 1'b1 || b0.rd_addr !== 6'(c-1)) begin
          n_err++; $display("FAIL nat_rd c=%0d got en=%b addr=%0d want 1 %0d", c, b0.rd_en, b0.rd_addr, c-1);
        end
      end
      if (c >= 3 && c <= 66) begin
        n_vec++;
        if (b0.dout_valid !== 1'b1 || b0.dout !== ram(6'(c-3)) || b0.dout_idx !== 6'(c-3)) begin
          n_err++; $display("FAIL nat_beat c=%0d got v=%b dout=%h idx=%0d want dout=%h idx=%0d",
            c, b0.dout_valid, b0.dout, b0.dout_idx, ram(6'(c-3)), c-3);
        end
      end
      n_vec++;
      if (done0 !== (c == 67)) begin n_err++; $display("FAIL nat_done c=%0d got %b want %b", c, done0, c == 67); end
      tick();
    end
  endtask

  task automatic test_start_busy();
    b1.dout_ready = 1; start1 = 1;
    tick(); start1 = 0;
    for (int c = 1; c <= 140; c++) begin
      start1 = (c == 20) || (c == 67);
      #1;
      if (c >= 21 && c <= 25) begin
        n_vec++;
        if (b1.dout_idx !== 6'(c-3) || busy1 !== 1'b1) begin
          n_err++; $display("FAIL sb_ignored c=%0d got idx=%0d busy=%b want idx=%0d busy=1", c, b1.dout_idx, busy1, c-3);
        end
      end
      if (c == 68) begin
        n_vec++;
        if (busy1 !== 1'b1 || b1.rd_en !== 1'b1 || b1.rd_addr !== 6'd0) begin
          n_err++; $display("FAIL sb_restart c=%0d got busy=%b en=%b addr=%0d want 1 1 0", c, busy1, b1.rd_en, b1.rd_addr);
        end
      end
      if (c == 70 || c == 71) begin
        n_vec++;
        if (b1.dout_valid !== 1'b1 || b1.dout_idx !== 6'(c-70) || b1.dout !== ram(brev(6'(c-70)))) begin
          n_err++; $display("FAIL sb_frame2 c=%0d got v=%b idx=%0d dout=%h want idx=%0d", c, b1.dout_valid, b1.dout_idx, b1.dout, c-70);
        end
      end
      n_vec++;
      if (done1 !== (c == 67 || c == 134)) begin
        n_err++; $display("FAIL sb_done c=%0d got %b want %b", c, done1, c == 67 || c == 134);
      end
      tick();
    end
    start1 = 0;
  endtask

  task automatic test_reset_mid();
    b1.dout_ready = 1; start1 = 1;
    tick(); start1 = 0;
    for (int c = 1; c < 30; c++) tick();
    rst = 1;
    #1;
    n_vec++;
    if (b1.rd_en !== 1'b1) begin n_err++; $display("FAIL rm_pre got rd_en=%b want 1", b1.rd_en); end
    tick(); rst = 0;
    #1;
    n_vec++;
    if ({busy1, trig1, done1, b1.rd_en, b1.rd_addr, b1.dout, b1.dout_valid,
         b1.dout_idx, b1.dout_last} !== '0) begin
      n_err++; $display("FAIL rm_outputs got busy=%b en=%b addr=%0d dout=%h v=%b idx=%0d want all 0",
        busy1, b1.rd_en, b1.rd_addr, b1.dout, b1.dout_valid, b1.dout_idx);
    end
    tick();
    #1;
    n_vec++;
    if (b1.dout_valid !== 1'b0 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL rm_discard got v=%b busy=%b want 0 0", b1.dout_valid, busy1);
    end
    start1 = 1;
    tick(); start1 = 0;
    for (int c = 33; c <= 100; c++) begin
      #1;
      if (c == 35) begin
        n_vec++;
        if (b1.dout_valid !== 1'b1 || b1.dout_idx !== 6'd0 || b1.dout !== ram(6'd0)) begin
          n_err++; $display("FAIL rm_first got v=%b idx=%0d dout=%h want 1 0 %h", b1.dout_valid, b1.dout_idx, b1.dout, ram(6'd0));
        end
      end
      n_vec++;
      if (done1 !== (c == 99)) begin n_err++; $display("FAIL rm_done c=%0d got %b want %b", c, done1, c == 99); end
      tick();
    end
  endtask

  task automatic test_last_stall();
    logic found = 0;
    b1.dout_ready = 1; start1 = 1;
    tick(); start1 = 0;
    for (int c = 1; c <= 100 && !found; c++) begin
      #1;
      if (b1.dout_valid && b1.dout_last) begin
        b1.dout_ready = 0; found = 1;
      end else tick();
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL ls_timeout got no dout_last want one within 100 cycles"); end
    for (int s = 0; s < 5; s++) begin
      b1.dout_ready = 0;
      #1;
      n_vec++;
      if (done1 !== 1'b0 || b1.dout_valid !== 1'b1 || b1.dout_last !== 1'b1 || b1.dout_idx !== 6'd63) begin
        n_err++; $display("FAIL ls_stall s=%0d got done=%b v=%b last=%b idx=%0d want 0 1 1 63",
          s, done1, b1.dout_valid, b1.dout_last, b1.dout_idx);
      end
      tick();
    end
    b1.dout_ready = 1;
    #1;
    n_vec++;
    if (done1 !== 1'b0 || b1.dout_last !== 1'b1) begin n_err++; $display("FAIL ls_xfer got done=%b last=%b want 0 1", done1, b1.dout_last); end
    tick();
    #1;
    n_vec++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || b1.dout_valid !== 1'b0) begin
      n_err++; $display("FAIL ls_done got done=%b busy=%b v=%b want 1 0 0", done1, busy1, b1.dout_valid);
    end
    tick();
    #1;
    n_vec++;
    if (done1 !== 1'b0) begin n_err++; $display("FAIL ls_pulse got done=%b want 0", done1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_natural();
    test_start_busy();
    test_reset_mid();
    test_last_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
